// File: rtl/reset_seq_if.sv
// Signal bundle between the reset sequencer and its consumers: raw lock and
// soft-reset request in, staged active-low subsystem resets and status out.
interface reset_seq_if;
    logic       locked_in;
    logic       soft_rst_req;
    logic       bus_reset_;
    logic       io_reset_;
    logic       cpu_reset_;
    logic       reset_done;
    logic [7:0] lock_loss_cnt;

    modport master (
        output locked_in,
        output soft_rst_req,
        input  bus_reset_,
        input  io_reset_,
        input  cpu_reset_,
        input  reset_done,
        input  lock_loss_cnt
    );

    modport slave (
        input  locked_in,
        input  soft_rst_req,
        output bus_reset_,
        output io_reset_,
        output cpu_reset_,
        output reset_done,
        output lock_loss_cnt
    );
endinterface

// File: rtl/reset_seq.sv
// Staged reset sequencer: waits for a stable synchronized clock lock, then
// releases bus, I/O and CPU resets in order; aborts on lock loss or soft request.
module reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    reset_seq_if.slave  rs
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_BUS   = 3'd2,
        REL_IO    = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_bus;
    logic                   r_io;
    logic                   r_cpu;
    logic                   r_done;
    logic                   w_bus_nxt;
    logic                   w_io_nxt;
    logic                   w_cpu_nxt;
    logic                   w_done_nxt;
    logic [7:0]             r_llc;
    logic [7:0]             w_llc_nxt;
    logic                   w_locked_s;
    logic                   w_abort;

    assign w_locked_s = r_sync[SYNC_STAGES-1];
    assign w_abort    = (~w_locked_s) | rs.soft_rst_req;

    // Lock synchronizer: locked_in is asynchronous to clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rs.locked_in};
        end
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bus_nxt   = r_bus;
        w_io_nxt    = r_io;
        w_cpu_nxt   = r_cpu;
        w_done_nxt  = r_done;
        w_llc_nxt   = r_llc;

        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt  = {CNT_W{1'b0}};
                w_bus_nxt  = 1'b0;
                w_io_nxt   = 1'b0;
                w_cpu_nxt  = 1'b0;
                w_done_nxt = 1'b0;
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end else begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = REL_BUS;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_bus_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            REL_BUS: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = REL_IO;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_io_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            REL_IO: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_cpu_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                w_cnt_nxt = {CNT_W{1'b0}};
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_bus_nxt   = 1'b0;
                w_io_nxt    = 1'b0;
                w_cpu_nxt   = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase

        // Abort wins over any normal progression; a combined soft+loss event counts once
        if ((r_state != WAIT_LOCK) && w_abort) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_bus_nxt   = 1'b0;
            w_io_nxt    = 1'b0;
            w_cpu_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
            if (!w_locked_s && (r_llc != 8'hFF)) begin
                w_llc_nxt = r_llc + 8'd1;
            end else begin
                w_llc_nxt = r_llc;
            end
        end else begin
            w_llc_nxt = r_llc;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= {CNT_W{1'b0}};
            r_bus   <= 1'b0;
            r_io    <= 1'b0;
            r_cpu   <= 1'b0;
            r_done  <= 1'b0;
            r_llc   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bus   <= w_bus_nxt;
            r_io    <= w_io_nxt;
            r_cpu   <= w_cpu_nxt;
            r_done  <= w_done_nxt;
            r_llc   <= w_llc_nxt;
        end
    end

    assign rs.bus_reset_    = r_bus;
    assign rs.io_reset_     = r_io;
    assign rs.cpu_reset_    = r_cpu;
    assign rs.reset_done    = r_done;
    assign rs.lock_loss_cnt = r_llc;

endmodule
